// File: rtl/led_flasher_if.sv
// Control/status bundle between the event source (master) and the LED flasher (slave).
interface led_flasher_if #(
    parameter int unsigned N_W = 4
);
    logic           start;
    logic [N_W-1:0] count;
    logic           abort;
    logic           led;
    logic           busy;
    logic           done;

    modport master (output start, count, abort, input led, busy, done);
    modport slave  (input start, count, abort, output led, busy, done);
endinterface

// File: rtl/led_flasher.sv
// Turns a single-cycle trigger into `count` ON/OFF LED flashes followed by a one-cycle done pulse.
module led_flasher #(
    parameter int unsigned ON_CYCLES  = 25000000,
    parameter int unsigned OFF_CYCLES = 25000000,
    parameter int unsigned CNT_W      = 25,
    parameter int unsigned N_W        = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    led_flasher_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ON, OFF, FIN} state_t;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [N_W-1:0]   remaining;

    // Outputs are registered alongside the state so they reflect the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            remaining <= '0;
            bus.led   <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        timer <= '0;
                        if (bus.count != '0) begin
                            remaining <= bus.count;
                            state     <= ON;
                            bus.led   <= 1'b1;
                            bus.busy  <= 1'b1;
                        end else begin
                            state    <= FIN;
                            bus.done <= 1'b1;
                        end
                    end
                end
                ON: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        timer     <= '0;
                        remaining <= '0;
                        bus.led   <= 1'b0;
                        bus.busy  <= 1'b0;
                    end else if (timer == ON_LAST) begin
                        timer   <= '0;
                        state   <= OFF;
                        bus.led <= 1'b0;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                OFF: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        timer     <= '0;
                        remaining <= '0;
                        bus.led   <= 1'b0;
                        bus.busy  <= 1'b0;
                    end else if (timer == OFF_LAST) begin
                        timer     <= '0;
                        remaining <= remaining - N_W'(1);
                        if (remaining == N_W'(1)) begin
                            state    <= FIN;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            state   <= ON;
                            bus.led <= 1'b1;
                        end
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                FIN: begin
                    // done drops via the default above; start and abort are both ignored here.
                    state    <= IDLE;
                    timer    <= '0;
                    bus.led  <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    timer     <= '0;
                    remaining <= '0;
                    bus.led   <= 1'b0;
                    bus.busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_flasher.sv
// Directed bench for led_flasher with ON_CYCLES=3, OFF_CYCLES=2.
module tb_led_flasher;
    localparam int unsigned ON_C  = 3;
    localparam int unsigned OFF_C = 2;
    localparam int unsigned PER   = ON_C + OFF_C;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    led_flasher_if #(.N_W(4)) bus ();

    led_flasher #(
        .ON_CYCLES (ON_C),
        .OFF_CYCLES(OFF_C),
        .CNT_W     (4),
        .N_W       (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one trigger at i=0 (plus optional extra start / abort) and checks every cycle.
    task automatic play(input string tag, input int cnt, input int extra_at,
                        input int abort_at, input int n_cyc);
        int ends;
        int el, eb, ed;
        ends = cnt * int'(PER);
        for (int i = 0; i < n_cyc; i++) begin
            bus.start = (i == 0) || (i == extra_at);
            bus.count = (i == 0) ? 4'(cnt) : 4'(7);
            bus.abort = (i == abort_at);
            step();
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (abort_at >= 0 && i >= abort_at) begin
                el = 0; eb = 0; ed = 0;
            end else begin
                el = ((i < ends) && ((i % int'(PER)) < int'(ON_C))) ? 1 : 0;
                eb = (i < ends) ? 1 : 0;
                ed = (i == ends) ? 1 : 0;
            end
            check($sformatf("%s led[%0d]", tag, i), int'(bus.led), el);
            check($sformatf("%s busy[%0d]", tag, i), int'(bus.busy), eb);
            check($sformatf("%s done[%0d]", tag, i), int'(bus.done), ed);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.count = '0;
        bus.abort = 1'b0;
        #1;
        check("reset led", int'(bus.led), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        play("cnt2", 2, -1, -1, 12);
        play("cnt0", 0, -1, -1, 3);
        play("restart", 3, 6, -1, 17);
        play("abort_off", 4, 9, 9, 12);
        play("after_abort", 1, -1, -1, 7);
        play("start_abort", 5, -1, 0, 8);
        play("start_in_fin", 1, 6, -1, 12);
        play("cnt_max", 15, -1, -1, 77);

        // Asynchronous reset mid-ON: outputs must fall without any clock edge.
        bus.start = 1'b1;
        bus.count = 4'(2);
        step();
        bus.start = 1'b0;
        step();
        check("pre_rst led", int'(bus.led), 1);
        check("pre_rst busy", int'(bus.busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst led", int'(bus.led), 0);
        check("async_rst busy", int'(bus.busy), 0);
        check("async_rst done", int'(bus.done), 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("post_rst led[%0d]", i), int'(bus.led), 0);
            check($sformatf("post_rst busy[%0d]", i), int'(bus.busy), 0);
            check($sformatf("post_rst done[%0d]", i), int'(bus.done), 0);
        end
        play("post_rst_run", 1, -1, -1, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
